// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    typedef enum logic [2:0] {
        BOOT,
        REQ,
        WAIT,
        HOLD,
        FAULT
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: loads the PC, issues one imem read per instruction, latches the IR,
// and computes the next PC when the control unit retires the instruction.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        pc_ld,
    output logic [31:0] pc_next,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] ir,
    output logic        ir_valid,
    input  logic        ir_ack,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        misalign,
    output logic        fetch_fault
);

    // The counter only ever holds 0..TIMEOUT-1; reaching TIMEOUT is the fault transition itself.
    localparam int unsigned   CW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    fetch_state_t  state;
    fetch_state_t  state_nx;
    logic [CW-1:0] tmo_cnt;
    logic          timeout_hit;

    assign timeout_hit = (state == WAIT) && !imem_rsp_valid && (tmo_cnt == LAST);
    assign imem_addr   = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BOOT;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt     <= '0;
            ir          <= '0;
            ir_valid    <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            if (state == REQ && imem_req_ready) begin
                tmo_cnt <= '0;
            end else if (state == WAIT && !imem_rsp_valid) begin
                tmo_cnt <= tmo_cnt + CW'(1);
            end

            if (state == WAIT && imem_rsp_valid) begin
                ir       <= imem_rsp_data;
                ir_valid <= 1'b1;
            end else if (state == HOLD && ir_ack) begin
                ir_valid <= 1'b0;
            end

            if (timeout_hit) begin
                fetch_fault <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            BOOT:    state_nx = REQ;
            REQ:     if (imem_req_ready) state_nx = WAIT;
            WAIT: begin
                if (imem_rsp_valid) begin
                    state_nx = HOLD;
                end else if (timeout_hit) begin
                    state_nx = FAULT;
                end
            end
            HOLD:    if (ir_ack) state_nx = REQ;
            FAULT:   state_nx = FAULT;
            default: state_nx = BOOT;
        endcase
    end

    // Strobes are forced low while rst is held so the PC is never loaded mid-reset.
    always_comb begin
        pc_ld          = 1'b0;
        pc_next        = '0;
        misalign       = 1'b0;
        imem_req_valid = 1'b0;
        if (!rst) begin
            case (state)
                BOOT: begin
                    pc_ld   = 1'b1;
                    pc_next = RESET_VEC;
                end
                REQ: begin
                    imem_req_valid = 1'b1;
                end
                HOLD: begin
                    if (ir_ack) begin
                        pc_ld    = 1'b1;
                        pc_next  = br_taken ? (br_target & ~32'h0000_0001)
                                            : pc + 32'(INSTR_BYTES);
                        misalign = br_taken && br_target[1];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: PC register, behavioural memory and control unit
// are driven cycle by cycle; expected values come from an instruction-level timeline model.
module tb_fetch_sequencer;
    import fetch_pkg::*;

    localparam logic [31:0] RST_VEC = 32'h0000_0100;
    localparam int          TMO     = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc  = '0;
    logic        pc_ld;
    logic [31:0] pc_next;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] ir;
    logic        ir_valid;
    logic        ir_ack;
    logic        br_taken;
    logic [31:0] br_target;
    logic        misalign;
    logic        fetch_fault;

    int vectors     = 0;
    int miscompares = 0;

    // One instruction: memory latencies, retire delay, redirect, and the expected results.
    typedef struct {
        int          ready_lat;
        int          rsp_lat;
        int          hold_lat;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] exp_addr;
        logic [31:0] exp_next;
        logic        exp_mis;
    } instr_vec_t;

    instr_vec_t  vecs[12];
    logic [31:0] model_pc;

    fetch_sequencer #(
        .RESET_VEC (RST_VEC),
        .TIMEOUT   (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .pc_ld          (pc_ld),
        .pc_next        (pc_next),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .ir             (ir),
        .ir_valid       (ir_valid),
        .ir_ack         (ir_ack),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .misalign       (misalign),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    // Plain loadable program counter register.
    always @(posedge clk) begin
        if (pc_ld) pc <= pc_next;
    end

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return {addr[15:0], addr[31:16]} ^ NOP_INSTR ^ 32'h5A00_0000;
    endfunction

    function automatic instr_vec_t mkVec(input int r, input int d, input int h, input logic br,
                                         input logic [31:0] tgt, input logic [31:0] addr,
                                         input logic [31:0] nxt, input logic mis);
        instr_vec_t v;
        v.ready_lat = r;
        v.rsp_lat   = d;
        v.hold_lat  = h;
        v.br        = br;
        v.tgt       = tgt;
        v.exp_addr  = addr;
        v.exp_next  = nxt;
        v.exp_mis   = mis;
        return v;
    endfunction

    // Reference: sequential step is +4 mod 2^32, a redirect drops bit 0 and flags bit 1.
    function automatic instr_vec_t randVec(input logic [31:0] addr);
        instr_vec_t v;
        v.ready_lat = int'($urandom_range(0, 3));
        v.rsp_lat   = int'($urandom_range(0, TMO - 1));
        v.hold_lat  = int'($urandom_range(0, 3));
        v.br        = ($urandom_range(0, 3) == 0);
        v.tgt       = $urandom;
        v.exp_addr  = addr;
        v.exp_next  = v.br ? (v.tgt - (v.tgt % 32'd2)) : (addr + 32'd4);
        v.exp_mis   = v.br && (((v.tgt / 32'd2) % 32'd2) == 32'd1);
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic rdy, input logic rspv, input logic [31:0] rspd,
                                 input logic ack, input logic br, input logic [31:0] tgt);
        imem_req_ready = rdy;
        imem_rsp_valid = rspv;
        imem_rsp_data  = rspd;
        ir_ack         = ack;
        br_taken       = br;
        br_target      = tgt;
    endtask

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    // Holds rst for two edges, then checks the BOOT load cycle; leaves the DUT entering REQ.
    task automatic doReset;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        nextCycle();
        nextCycle();
        @(negedge clk);
        checkOutput("rst_pc_ld", pc_ld, 0);
        checkOutput("rst_req_valid", imem_req_valid, 0);
        checkOutput("rst_ir_valid", ir_valid, 0);
        checkOutput("rst_ir", ir, 0);
        checkOutput("rst_fault", fetch_fault, 0);
        checkOutput("rst_misalign", misalign, 0);
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("boot_pc_ld", pc_ld, 1);
        checkOutput("boot_pc_next", pc_next, RST_VEC);
        checkOutput("boot_req_valid", imem_req_valid, 0);
        checkOutput("boot_fault", fetch_fault, 0);
        nextCycle();
    endtask

    // Runs one instruction from its first REQ cycle to the edge ending its load cycle.
    task automatic runInstr(input instr_vec_t v);
        for (int i = 0; i <= v.ready_lat; i++) begin
            applyStimulus(i == v.ready_lat, 1'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom);
            @(negedge clk);
            checkOutput("req_valid", imem_req_valid, 1);
            checkOutput("req_addr", imem_addr, v.exp_addr);
            checkOutput("req_pc_ld", pc_ld, 0);
            checkOutput("req_ir_valid", ir_valid, 0);
            nextCycle();
        end
        for (int j = 0; j <= v.rsp_lat; j++) begin
            applyStimulus(1'($urandom), j == v.rsp_lat, (j == v.rsp_lat) ? memWord(v.exp_addr) : $urandom,
                          1'($urandom), 1'($urandom), $urandom);
            @(negedge clk);
            checkOutput("wait_req_valid", imem_req_valid, 0);
            checkOutput("wait_ir_valid", ir_valid, 0);
            checkOutput("wait_pc_ld", pc_ld, 0);
            checkOutput("wait_fault", fetch_fault, 0);
            nextCycle();
        end
        for (int k = 0; k <= v.hold_lat; k++) begin
            if (k == v.hold_lat) begin
                applyStimulus(1'($urandom), 1'($urandom), $urandom, 1'b1, v.br, v.tgt);
            end else begin
                applyStimulus(1'($urandom), 1'($urandom), $urandom, 1'b0, 1'($urandom), $urandom | 32'h2);
            end
            @(negedge clk);
            checkOutput("hold_ir_valid", ir_valid, 1);
            checkOutput("hold_ir", ir, memWord(v.exp_addr));
            checkOutput("hold_req_valid", imem_req_valid, 0);
            checkOutput("hold_pc_ld", pc_ld, (k == v.hold_lat) ? 1 : 0);
            checkOutput("hold_misalign", misalign, (k == v.hold_lat) ? v.exp_mis : 1'b0);
            if (k == v.hold_lat) checkOutput("hold_pc_next", pc_next, v.exp_next);
            nextCycle();
        end
    endtask

    task automatic runRandom(input int n);
        instr_vec_t v;
        for (int i = 0; i < n; i++) begin
            v = randVec(model_pc);
            runInstr(v);
            model_pc = v.exp_next;
        end
    endtask

    initial begin
        vecs[0]  = mkVec(0, 0, 0, 1'b1, 32'h0000_0000, 32'h0000_0100, 32'h0000_0000, 1'b0);
        vecs[1]  = mkVec(0, 0, 0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0004, 1'b0);
        vecs[2]  = mkVec(0, 0, 0, 1'b0, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008, 1'b0);
        vecs[3]  = mkVec(0, 0, 0, 1'b0, 32'h0000_0000, 32'h0000_0008, 32'h0000_000C, 1'b0);
        vecs[4]  = mkVec(4, 3, 1, 1'b0, 32'h0000_0000, 32'h0000_000C, 32'h0000_0010, 1'b0);
        vecs[5]  = mkVec(1, 0, 0, 1'b1, 32'h0000_0020, 32'h0000_0010, 32'h0000_0020, 1'b0);
        vecs[6]  = mkVec(0, 1, 0, 1'b1, 32'h0000_0047, 32'h0000_0020, 32'h0000_0046, 1'b1);
        vecs[7]  = mkVec(0, 0, 2, 1'b1, 32'h0000_0020, 32'h0000_0046, 32'h0000_0020, 1'b0);
        vecs[8]  = mkVec(0, 0, 0, 1'b1, 32'h0000_0041, 32'h0000_0020, 32'h0000_0040, 1'b0);
        vecs[9]  = mkVec(0, 2, 0, 1'b1, 32'hFFFF_FFFD, 32'h0000_0040, 32'hFFFF_FFFC, 1'b0);
        vecs[10] = mkVec(0, 0, 0, 1'b0, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0);
        vecs[11] = mkVec(2, TMO - 1, 0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0004, 1'b0);

        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        doReset();

        foreach (vecs[i]) runInstr(vecs[i]);
        model_pc = 32'h0000_0004;

        runRandom(150);

        // Reset lands in the first WAIT cycle together with a response.
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        @(negedge clk);
        checkOutput("rw_req_addr", imem_addr, model_pc);
        nextCycle();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b1, memWord(model_pc), 1'b0, 1'b0, '0);
        @(negedge clk);
        checkOutput("rw_pc_ld", pc_ld, 0);
        checkOutput("rw_req_valid", imem_req_valid, 0);
        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, $urandom, 1'b1, 1'b0, '0);
        @(negedge clk);
        checkOutput("rw_ir_valid", ir_valid, 0);
        checkOutput("rw_ir", ir, 0);
        checkOutput("rw_boot_pc_ld", pc_ld, 1);
        checkOutput("rw_boot_pc_next", pc_next, RST_VEC);
        nextCycle();
        model_pc = RST_VEC;
        runRandom(2);

        // No response: the fault must appear after exactly TMO WAIT cycles and stick.
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        @(negedge clk);
        checkOutput("to_req_valid", imem_req_valid, 1);
        nextCycle();
        for (int w = 1; w <= TMO; w++) begin
            applyStimulus(1'($urandom), 1'b0, $urandom, 1'($urandom), 1'($urandom), $urandom);
            @(negedge clk);
            checkOutput("to_wait_fault", fetch_fault, 0);
            checkOutput("to_wait_req_valid", imem_req_valid, 0);
            nextCycle();
        end
        for (int f = 0; f < 5; f++) begin
            applyStimulus(1'b1, 1'b1, $urandom, 1'b1, 1'b1, $urandom | 32'h2);
            @(negedge clk);
            checkOutput("fault_flag", fetch_fault, 1);
            checkOutput("fault_req_valid", imem_req_valid, 0);
            checkOutput("fault_pc_ld", pc_ld, 0);
            checkOutput("fault_misalign", misalign, 0);
            checkOutput("fault_ir_valid", ir_valid, 0);
            nextCycle();
        end
        doReset();
        model_pc = RST_VEC;
        runRandom(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Drives the load side of the program counter register, so the counter itself stays a plain loadable register.
- Holds `pc_ld`/`pc_next` and issues one instruction-memory read per instruction over a valid/ready request and valid response interface.
- Latches the returned instruction into an IR and hands it to the multicycle control unit.
- Computes the next PC (sequential or redirected) when the control unit retires the instruction.

Parameters:
RESET_VEC, 32'h0000_0000, PC value loaded after reset.
TIMEOUT, 255, max cycles spent in WAIT before a fetch fault; must be ≥1.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
pc  in  32  current program counter value
pc_ld  out  1  load strobe to program counter
pc_next  out  32  value to load into program counter
imem_req_valid  out  1  instruction read request valid
imem_req_ready  in  1  memory accepts request
imem_addr  out  32  request address (equals pc)
imem_rsp_valid  in  1  read data valid
imem_rsp_data  in  32  read data
ir  out  32  latched instruction
ir_valid  out  1  ir holds an unconsumed instruction
ir_ack  in  1  control unit retires current instruction
br_taken  in  1  with ir_ack: redirect to br_target
br_target  in  32  redirect address
misalign  out  1  one-cycle pulse: redirect target[1] set
fetch_fault  out  1  sticky: WAIT timed out

Behaviour:
- Clock `clk`; reset `rst` is synchronous, active-high. Single clock domain.
- Reset values: state=BOOT, `pc_ld`=0, `pc_next`=0, `imem_req_valid`=0, `ir`=0, `ir_valid`=0, `misalign`=0, `fetch_fault`=0, timeout counter=0.
- FSM states: BOOT, REQ, WAIT, HOLD, FAULT.
- BOOT: `pc_ld`=1, `pc_next`=RESET_VEC for exactly one cycle -> REQ.
- REQ:
  - `imem_req_valid`=1, `imem_addr`=`pc`.
  - Hold valid and address stable until `imem_req_ready`.
  - Handshake cycle -> WAIT; timeout counter cleared.
- WAIT:
  - `imem_req_valid`=0.
  - On `imem_rsp_valid`: `ir`<=`imem_rsp_data`, `ir_valid`<=1 -> HOLD.
  - Otherwise the counter increments; when it reaches TIMEOUT without a response -> FAULT.
- HOLD:
  - `ir` stable, `ir_valid`=1.
  - On `ir_ack`: `ir_valid`<=0, `pc_ld`=1 for one cycle, -> REQ.
  - `pc_next` = `br_taken` ? {`br_target`[31:1],1'b0} : `pc`+4, with mod-2^32 wrap (32'hFFFF_FFFC+4 = 0).
- Misaligned redirect: if `br_taken` and `br_target`[1]=1, pulse `misalign` in the same cycle as `pc_ld`; the load still proceeds.
- FAULT: `fetch_fault`=1, all strobes 0; exit only via `rst`.
- Outputs are registered except `imem_req_valid`/`imem_addr` (decoded from state/`pc`) and `pc_ld`/`pc_next`/`misalign` (decoded from state and inputs, combinational in the load cycle).
- Sequencing: the PC updates at the edge ending the `pc_ld` cycle, so REQ in the next cycle sees the new `pc`.
- Ignored inputs:
  - `imem_rsp_valid` outside WAIT (no outstanding request; at most one request in flight).
  - `ir_ack` outside HOLD.
  - `br_taken` without `ir_ack`.
- Response in the same cycle the counter would hit TIMEOUT: the response wins -> HOLD.
- `rst` mid-operation (any state) returns to BOOT next cycle. Memory shares `rst`, so no stale response is possible.
- Minimum loop with zero-wait memory: REQ(1) + WAIT(1) + HOLD(≥1) = 3 cycles per instruction.

Decomposition:
- Shared package `fetch_pkg`:
  - `fetch_state_t` enum (BOOT, REQ, WAIT, HOLD, FAULT).
  - `INSTR_BYTES`=4.
  - `NOP_INSTR`=32'h0000_0013, for bench use.
- No sub-module: FSM, IR register and timeout counter live in one module.
- The bench instantiates this block plus the program counter register and a behavioural memory model with configurable ready/response latency.

Test Plan:
1. Reset release with RESET_VEC=32'h100 -> `pc_ld`=1 / `pc_next`=32'h100 in cycle 1; `imem_req_valid`=1, `imem_addr`=32'h100 in cycle 2.
2. Zero-wait memory, `ir_ack` held high, no branches -> fetch addresses 0x0, 0x4, 0x8, 0xC, one every 3 cycles; `ir` matches memory words.
3. `imem_req_ready` low 4 cycles, then response delayed 3 cycles -> valid/addr stable throughout; `ir_valid` rises only after the response; no extra request.
4. In HOLD at pc=0x20: `ir_ack`=1, `br_taken`=1, `br_target`=0x47 -> `pc_next`=0x46, `misalign` pulses, next fetch address 0x46. Same with target 0x41 -> `pc_next`=0x40, no pulse.
5. TIMEOUT=8, no response -> `fetch_fault` sets on the 8th WAIT cycle and stays; then `rst` -> BOOT, fault cleared, fetching resumes at RESET_VEC.
6. `pc`=32'hFFFF_FFFC, sequential ack -> `pc_next`=0. Separately, assert `rst` in WAIT with a response arriving in the same cycle -> `ir_valid` stays 0 and the FSM is in BOOT.
